// File: rtl/barrel_pkg.sv
// Shared widths and flat-bus field helpers for the shift arbiter.
package barrel_pkg;

   localparam int DATA_W   = 8;
   localparam int AMT_W    = 3;
   localparam int MAX_NREQ = 8;

   // Request buses are zero-padded to MAX_NREQ lanes so one helper serves any NREQ.
   function automatic logic [DATA_W-1:0] get_data(input logic [DATA_W*MAX_NREQ-1:0] flat,
                                                   input int                          k);
      return flat[k*DATA_W +: DATA_W];
   endfunction

   function automatic logic [AMT_W-1:0] get_amt(input logic [AMT_W*MAX_NREQ-1:0] flat,
                                                 input int                         k);
      return flat[k*AMT_W +: AMT_W];
   endfunction

endpackage

// File: rtl/barrel_shifter.sv
// 8-bit logical left shifter, zero fill, three-level log structure.
module barrel_shifter (
   input  logic [7:0] data_in,
   input  logic [2:0] amt,
   output logic [7:0] data_out
);

   logic [7:0] sh1;
   logic [7:0] sh2;

   assign sh1      = amt[0] ? {data_in[6:0], 1'b0} : data_in;
   assign sh2      = amt[1] ? {sh1[5:0], 2'b00}    : sh1;
   assign data_out = amt[2] ? {sh2[3:0], 4'h0}     : sh2;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  winner
);

   logic [IDW-1:0] idx;

   // Scan offsets from farthest to nearest so the nearest set request is left in winner.
   always_comb begin
      grant  = '0;
      winner = '0;
      idx    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = IDW'((int'(ptr) + i) % NREQ);
         if (req[idx]) winner = idx;
      end
      if (en && (|req)) grant[winner] = 1'b1;
   end

endmodule

// File: rtl/barrel_arbiter.sv
// Round-robin front end sharing one barrel_shifter among NREQ requesters,
// with an operand stage and a result stage under full consumer backpressure.
module barrel_arbiter
   import barrel_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [DATA_W*NREQ-1:0] req_data,
   input  logic [AMT_W*NREQ-1:0]  req_amt,
   output logic [NREQ-1:0]        req_ready,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic [IDW-1:0]         out_id,
   input  logic                   out_ready,
   output logic [CNTW-1:0]        ops_done
);

   logic                         advance;
   logic                         accept;
   logic [NREQ-1:0]              grant;
   logic [IDW-1:0]               winner;
   logic [DATA_W*MAX_NREQ-1:0]   data_flat;
   logic [AMT_W*MAX_NREQ-1:0]    amt_flat;
   logic [DATA_W-1:0]            shift_res;

   logic [IDW-1:0]    ptr_q,       ptr_d;
   logic              s1_valid_q,  s1_valid_d;
   logic [DATA_W-1:0] s1_data_q,   s1_data_d;
   logic [AMT_W-1:0]  s1_amt_q,    s1_amt_d;
   logic [IDW-1:0]    s1_id_q,     s1_id_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [IDW-1:0]    out_id_q,    out_id_d;
   logic [CNTW-1:0]   ops_done_q,  ops_done_d;

   assign data_flat = (DATA_W*MAX_NREQ)'(req_data);
   assign amt_flat  = (AMT_W*MAX_NREQ)'(req_amt);

   // Whole pipeline moves together; only a held result with no consumer stalls it.
   assign advance = !out_valid_q | out_ready;

   // rst_n gates the grant so no requester sees ready while reset is asserted.
   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req    (req_valid),
      .ptr    (ptr_q),
      .en     (advance & rst_n),
      .grant  (grant),
      .winner (winner)
   );

   assign req_ready = grant;
   assign accept    = |grant;

   barrel_shifter u_shift (
      .data_in  (s1_data_q),
      .amt      (s1_amt_q),
      .data_out (shift_res)
   );

   // Next-state for pointer, both pipeline stages and the completion counter.
   always_comb begin
      ptr_d       = ptr_q;
      s1_valid_d  = s1_valid_q;
      s1_data_d   = s1_data_q;
      s1_amt_d    = s1_amt_q;
      s1_id_d     = s1_id_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      ops_done_d  = ops_done_q;

      if (accept) begin
         ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
      end

      if (advance) begin
         s1_valid_d  = |req_valid;
         s1_data_d   = get_data(data_flat, int'(winner));
         s1_amt_d    = get_amt(amt_flat, int'(winner));
         s1_id_d     = winner;
         out_valid_d = s1_valid_q;
         out_data_d  = shift_res;
         out_id_d    = s1_id_q;
      end

      if (out_valid_q && out_ready) begin
         ops_done_d = ops_done_q + 1'b1;
      end
   end

   // State registers; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_amt_q    <= '0;
         s1_id_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         ops_done_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_amt_q    <= s1_amt_d;
         s1_id_q     <= s1_id_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         ops_done_q  <= ops_done_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_barrel_arbiter.sv
// Scoreboard bench for barrel_arbiter: predictor pushes expected results on
// modelled grants, monitor pops and compares on each consumer handshake.
module tb_barrel_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CNTW = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [8*NREQ-1:0]    req_data;
   logic [3*NREQ-1:0]    req_amt;
   logic [NREQ-1:0]      req_ready;
   logic                 out_valid;
   logic [7:0]           out_data;
   logic [IDW-1:0]       out_id;
   logic                 out_ready;
   logic [CNTW-1:0]      ops_done;

   always #5 clk = ~clk;

   barrel_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW),
      .CNTW (CNTW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_amt   (req_amt),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready),
      .ops_done  (ops_done)
   );

   typedef struct {
      int id;
      int data;
   } res_t;

   int   n_cmp = 0;
   int   n_err = 0;
   res_t sb_q[$];

   bit         pv[NREQ];
   logic [7:0] pd[NREQ];
   logic [2:0] pa[NREQ];
   bit         acc[NREQ];
   int         mode = 0;
   int         m_ptr = 0;
   bit         m_s1v = 1'b0;
   bit         m_outv = 1'b0;
   int         m_done = 0;
   bit         wrap_seen = 1'b0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic drive();
      for (int k = 0; k < NREQ; k++) begin
         req_valid[k]       = pv[k];
         req_data[8*k +: 8] = pd[k];
         req_amt[3*k +: 3]  = pa[k];
      end
   endtask

   // Predictor: round-robin over the current request set, pipeline occupancy as two flags.
   always @(negedge clk) begin
      int win;
      bit adv;
      logic [NREQ-1:0] exp_g;
      if (!rst_n) begin
         m_ptr  = 0;
         m_s1v  = 1'b0;
         m_outv = 1'b0;
         sb_q.delete();
         chk("rst_req_ready", 32'(req_ready), 32'(0));
         chk("rst_out_valid", 32'(out_valid), 32'(0));
      end else begin
         adv = !m_outv || out_ready;
         chk("out_valid", 32'(out_valid), 32'(m_outv));
         win = -1;
         for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_ptr + i) % NREQ;
            if (win < 0 && req_valid[k]) win = k;
         end
         exp_g = '0;
         if (adv && win >= 0) exp_g[win] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(exp_g));
         if (adv) begin
            m_outv = m_s1v;
            m_s1v  = (win >= 0);
            if (win >= 0) begin
               sb_q.push_back('{win, (int'(pd[win]) << pa[win]) % 256});
               m_ptr    = (win + 1) % NREQ;
               acc[win] = 1'b1;
            end
         end
      end
   end

   // Monitor: compare presented results against the scoreboard head, count completions.
   always @(negedge clk) begin
      res_t r;
      if (!rst_n) begin
         m_done = 0;
         chk("rst_ops_done", 32'(ops_done), 32'(0));
      end else begin
         if (m_done == 65536) begin
            wrap_seen = 1'b1;
            chk("ops_done_wrap", 32'(ops_done), 32'(0));
         end
         chk("ops_done", 32'(ops_done), 32'(m_done % 65536));
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_output: got id %0d data %0h expected none", out_id, out_data);
            end else if (out_ready) begin
               r = sb_q.pop_front();
               chk("out_data", 32'(out_data), 32'(r.data));
               chk("out_id", 32'(out_id), 32'(r.id));
               m_done++;
            end else begin
               chk("stall_data", 32'(out_data), 32'(sb_q[0].data));
               chk("stall_id", 32'(out_id), 32'(sb_q[0].id));
            end
         end
      end
   end

   // Advance one cycle: retire accepted requests and generate new ones per mode.
   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
         if (acc[k]) begin
            acc[k] = 1'b0;
            pv[k]  = (mode == 1);
         end
      end
      if (mode == 2) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!pv[k]) begin
               if ($urandom_range(0, 2) == 0) begin
                  pv[k] = 1'b1;
                  pd[k] = 8'($urandom);
                  pa[k] = 3'($urandom);
               end
            end else if ($urandom_range(0, 15) == 0) begin
               pv[k] = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      drive();
   endtask

   task automatic single_op(int k, logic [7:0] d, logic [2:0] a, logic [7:0] exp_d, int exp_done);
      logic [NREQ-1:0] exp_g;
      mode = 0;
      @(posedge clk);
      #1;
      pv[k] = 1'b1;
      pd[k] = d;
      pa[k] = a;
      out_ready = 1'b1;
      drive();
      exp_g = '0;
      exp_g[k] = 1'b1;
      @(negedge clk);
      chk("single_ready", 32'(req_ready), 32'(exp_g));
      step();
      @(negedge clk);
      chk("single_one_grant", 32'(req_ready), 32'(0));
      step();
      @(negedge clk);
      chk("single_valid", 32'(out_valid), 32'(1));
      chk("single_data", 32'(out_data), 32'(exp_d));
      chk("single_id", 32'(out_id), 32'(k));
      step();
      @(negedge clk);
      chk("single_done", 32'(ops_done), 32'(exp_done));
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < NREQ; k++) begin
         pv[k]  = 1'b0;
         pd[k]  = '0;
         pa[k]  = '0;
         acc[k] = 1'b0;
      end
      drive();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // idle after reset
      repeat (10) step();

      // directed single operations and shift boundaries
      single_op(2, 8'hB5, 3'd3, 8'hA8, 1);
      single_op(0, 8'hFF, 3'd7, 8'h80, 2);
      single_op(3, 8'h01, 3'd0, 8'h01, 3);

      // round robin with every requester continuously valid
      @(posedge clk);
      #1;
      mode = 1;
      for (int k = 0; k < NREQ; k++) begin
         pv[k] = 1'b1;
         pd[k] = 8'(8'h10 + k);
         pa[k] = 3'd0;
      end
      out_ready = 1'b1;
      drive();
      step();
      for (int i = 0; i < 8; i++) begin
         step();
         @(negedge clk);
         chk("rr_valid", 32'(out_valid), 32'(1));
         chk("rr_id", 32'(out_id), 32'(i % NREQ));
         chk("rr_data", 32'(out_data), 32'(8'h10 + (i % NREQ)));
      end

      // backpressure with a full pipeline
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      drive();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_ready", 32'(req_ready), 32'(0));
         step();
      end
      out_ready = 1'b1;
      repeat (10) step();

      // drain, then randomized traffic
      mode = 0;
      for (int k = 0; k < NREQ; k++) pv[k] = 1'b0;
      repeat (5) step();
      mode = 2;
      repeat (3000) step();
      mode = 0;
      out_ready = 1'b1;
      for (int k = 0; k < NREQ; k++) pv[k] = 1'b0;
      repeat (6) step();

      // reset while both stages hold operations
      mode = 1;
      for (int k = 0; k < NREQ; k++) begin
         pv[k] = 1'b1;
         pd[k] = 8'($urandom);
         pa[k] = 3'($urandom);
      end
      drive();
      repeat (4) step();
      @(posedge clk);
      #1;
      chk("pre_rst_full", 32'(out_valid), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'(0));
      mode = 0;
      for (int k = 0; k < NREQ; k++) begin
         pv[k]  = 1'b0;
         acc[k] = 1'b0;
      end
      drive();
      repeat (2) step();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mode  = 1;
      for (int k = 0; k < NREQ; k++) pv[k] = 1'b1;
      drive();
      @(negedge clk);
      chk("rst_first_grant", 32'(req_ready), 32'(4'b0001));

      // completion counter wrap at full throughput
      repeat (65545) step();
      mode = 0;
      for (int k = 0; k < NREQ; k++) pv[k] = 1'b0;
      repeat (6) step();
      @(negedge clk);
      chk("wrap_seen", 32'(wrap_seen), 32'(1));
      chk("sb_empty", 32'(sb_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "timeout");
   end

endmodule
